muldiv_unit_with_lock: RTL and testbench
========================================

// Module: muldiv_unit_with_lock
// PURPOSE
// - Shared iterative MULT/MULTU/DIV/DIVU responder on the SIC resource-pool-lock handshake.
// - Same lock protocol the SICs already drive toward the ALU pool and data memory.
// - Grants one owner at a time, oldest issue ID first.
// - Runs a 32-step shift-add multiply or restoring divide, then holds the HI/LO result until the owner releases the lock.
// PARAMETERS
// - NUM_PORTS  default 2   number of SIC request ports
// - ID_WIDTH   default 16  issue-ID width; IDs wrap modulo 2**ID_WIDTH
// PORTS
// - clk        in   1                  clock
// - rst        in   1                  reset; synchronous, active-high
// - lock_req   in   [NUM_PORTS]        SIC holds high to request and keep the lock
// - lock_id    in   [NUM_PORTS][ID_WIDTH]  issue ID of the requester
// - start      in   [NUM_PORTS]        1-cycle operation launch; honoured only from the owner in LOCKED
// - op         in   [NUM_PORTS][1:0]   0=MULT 1=MULTU 2=DIV 3=DIVU
// - opa, opb   in   [NUM_PORTS][31:0]  operands (rs, rt), sampled with start
// - grant      out  [NUM_PORTS]        one-hot; high for the owner while locked
// - done       out  1                  result valid; meaningful to the owner only
// - result_hi  out  32                 HI: mult high word / remainder
// - result_lo  out  32                 LO: mult low word / quotient
// - busy       out  1                  high in any state other than IDLE
// BEHAVIOUR
// Reset: state=IDLE; grant=0; done=0; result_hi/lo=0; busy=0; step counter=0. Reset mid-operation discards all work.
// States:
// - IDLE: if any lock_req is high, choose the winner.
//   - Winner = port whose lock_id is oldest: A is older than B iff $signed(A-B) < 0 in ID_WIDTH bits (wrap-aware).
//   - Equal IDs: the lower port index wins.
//   - Next cycle: grant[winner]=1, go to LOCKED.
// - LOCKED:
//   - Owner lock_req=0 -> IDLE; grant drops the next cycle.
//   - Owner start=1 -> latch op/opa/opb, cnt=0, done=0, go to BUSY.
//   - start from non-owners is ignored in every state.
// - BUSY: one iteration per cycle; after 32 iterations -> DONE.
//   - Start accepted at cycle t => done=1 and results valid from cycle t+33.
//   - Owner lock_req=0 while BUSY is an abort (rollback): -> IDLE the next cycle, results are not updated, done stays 0.
// - DONE: done=1; result_hi/lo held stable.
//   - Owner start=1 -> new op, back to BUSY (pipelined reuse without relocking); done drops the next cycle.
//   - Owner lock_req=0 -> IDLE; done=0 the next cycle.
// - No arbitration happens outside IDLE. Other requesters wait; their lock_req stays high.
// - The owner releases in one cycle and the next winner is granted two cycles later (IDLE arbitration cycle).
// Arithmetic:
// - MULTU: {hi,lo} = opa*opb, 64-bit unsigned.
// - MULT: multiply the magnitudes, negate the 64-bit product if the signs differ.
// - DIVU: lo = opa/opb, hi = opa%opb.
// - DIV: divide the magnitudes. Negate the quotient if sign(a)^sign(b); the remainder takes sign(a).
// - Divide by zero (DIV/DIVU): lo = 32'hFFFF_FFFF, hi = opa, same 33-cycle latency.
// - DIV 32'h8000_0000 / -1: lo = 32'h8000_0000, hi = 0, no trap.
// - All magnitudes are 32-bit unsigned. The 0x8000_0000 magnitude is exact; no widening beyond 33-bit remainder/64-bit product.
// TESTING
// 1. Reset check: assert rst mid-BUSY -> next cycle grant=0, done=0, busy=0, result=0.
// 2. Single MULT by port0, id=5, opa=-3, opb=7; start at t -> done at t+33, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
// 3. Arbitration with wrap: port0 id=16'h0001, port1 id=16'hFFFE, both requesting in IDLE.
//    -> grant=2'b10. Port1 releases -> port0 granted 2 cycles later.
// 4. DIV opa=-7, opb=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
//    Then DIVU opa=10, opb=0 issued from DONE without release -> lo=32'hFFFF_FFFF, hi=10.
// 5. Abort: owner drops lock_req at cycle 10 of BUSY -> IDLE next cycle, done never rises.
//    Waiting port granted 2 cycles after the drop; held results unchanged.
// 6. Non-owner start pulses during LOCKED and BUSY are ignored. DIV 32'h8000_0000 / 32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.

Source files
------------

// File: rtl/muldiv_unit_with_lock.sv
// Shared iterative multiply/divide unit behind the SIC resource-pool lock.
// Grants the lock to the oldest requester, runs a 32-step shift-add multiply
// or restoring divide, and holds HI/LO until the owner releases the lock.
module muldiv_unit_with_lock #(
  parameter int NUM_PORTS = 2,
  parameter int ID_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               lock_req,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] lock_id,
  input  logic [NUM_PORTS-1:0]               start,
  input  logic [NUM_PORTS-1:0][1:0]          op,
  input  logic [NUM_PORTS-1:0][31:0]         opa,
  input  logic [NUM_PORTS-1:0][31:0]         opb,
  output logic [NUM_PORTS-1:0]               grant,
  output logic                               done,
  output logic [31:0]                        result_hi,
  output logic [31:0]                        result_lo,
  output logic                               busy
);

  localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCKED,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_t;

  state_t        state, state_nxt;
  logic [OW-1:0] owner;
  logic [OW-1:0] win;
  logic [4:0]    cnt;

  // Operation context latched at start
  op_t         op_r;
  logic        neg_a, neg_b, b_zero;
  logic [31:0] a_raw, ma, mb;

  // Shared working register: product {hi,lo} for multiply,
  // {remainder, quotient/dividend} for divide
  logic [63:0] acc, acc_nxt;

  logic own_req, own_start;
  logic arb_take, accept, step, finish;

  // Launch-side decode of the owner's operands
  op_t         op_in;
  logic        signed_in, neg_a_in, neg_b_in;
  logic [31:0] ma_in, mb_in;

  // Iteration datapath
  logic [32:0] mul_sum, trial, rem_new;
  logic        ge;
  logic [31:0] fin_hi, fin_lo;
  logic [63:0] prod_neg;

  assign own_req   = lock_req[owner];
  assign own_start = start[owner];

  // Oldest-ID arbitration; strict "older" comparison keeps the lower index on ties
  always_comb begin
    logic                found;
    logic [ID_WIDTH-1:0] best_id;
    logic [ID_WIDTH-1:0] diff;
    found   = 1'b0;
    best_id = '0;
    diff    = '0;
    win     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      diff = lock_id[i] - best_id;
      if (lock_req[i] && (!found || diff[ID_WIDTH-1])) begin
        found   = 1'b1;
        best_id = lock_id[i];
        win     = OW'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control strobes; release by the owner beats a same-cycle start
  always_comb begin
    state_nxt = state;
    arb_take  = 1'b0;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|lock_req) begin
          arb_take  = 1'b1;
          state_nxt = S_LOCKED;
        end
      end
      S_LOCKED, S_DONE: begin
        if (!own_req) begin
          state_nxt = S_IDLE;
        end else if (own_start) begin
          accept    = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!own_req)         state_nxt = S_IDLE;
        else if (cnt == 5'd31) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign step   = (state == S_BUSY) && own_req;
  assign finish = step && (cnt == 5'd31);

  // Outputs derived from state and owner
  always_comb begin
    grant = '0;
    if (state != S_IDLE) grant[owner] = 1'b1;
  end

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);

  // Operand sign handling at launch
  always_comb begin
    op_in     = op_t'(op[owner]);
    signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
    neg_a_in  = signed_in && opa[owner][31];
    neg_b_in  = signed_in && opb[owner][31];
    ma_in     = neg_a_in ? (32'd0 - opa[owner]) : opa[owner];
    mb_in     = neg_b_in ? (32'd0 - opb[owner]) : opb[owner];
  end

  // One shift-add or restoring-divide iteration on the working register
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, ma} : 33'd0);
    trial   = {acc[63:32], acc[31]};
    ge      = (trial >= {1'b0, mb});
    rem_new = ge ? (trial - {1'b0, mb}) : trial;
    if ((op_r == OP_DIV) || (op_r == OP_DIVU))
      acc_nxt = {rem_new[31:0], acc[30:0], ge};
    else
      acc_nxt = {mul_sum, acc[31:1]};
  end

  // Sign fix-up of the final iteration's value; divide-by-zero overrides
  always_comb begin
    fin_hi   = acc_nxt[63:32];
    fin_lo   = acc_nxt[31:0];
    prod_neg = 64'd0 - acc_nxt;
    unique case (op_r)
      OP_MULT: begin
        if (neg_a ^ neg_b) begin
          fin_hi = prod_neg[63:32];
          fin_lo = prod_neg[31:0];
        end
      end
      OP_DIV: begin
        if (b_zero) begin
          fin_hi = a_raw;
          fin_lo = '1;
        end else begin
          fin_lo = (neg_a ^ neg_b) ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
          fin_hi = neg_a ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
        end
      end
      OP_DIVU: begin
        if (b_zero) begin
          fin_hi = a_raw;
          fin_lo = '1;
        end
      end
      default: begin
      end
    endcase
  end

  // Owner, operation context, iteration state and held results
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= '0;
      cnt       <= '0;
      acc       <= '0;
      op_r      <= OP_MULT;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      b_zero    <= 1'b0;
      a_raw     <= '0;
      ma        <= '0;
      mb        <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      if (arb_take) owner <= win;
      if (accept) begin
        op_r   <= op_in;
        neg_a  <= neg_a_in;
        neg_b  <= neg_b_in;
        b_zero <= (opb[owner] == 32'd0);
        a_raw  <= opa[owner];
        ma     <= ma_in;
        mb     <= mb_in;
        cnt    <= '0;
        if ((op_in == OP_DIV) || (op_in == OP_DIVU)) acc <= {32'd0, ma_in};
        else                                         acc <= {32'd0, mb_in};
      end else if (step) begin
        acc <= acc_nxt;
        cnt <= cnt + 5'd1;
        if (finish) begin
          result_hi <= fin_hi;
          result_lo <= fin_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit_with_lock.sv
// Bench for muldiv_unit_with_lock: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed literal results.
module tb_muldiv_unit_with_lock;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        lock_req;
  logic [1:0][15:0]  lock_id;
  logic [1:0]        start;
  logic [1:0][1:0]   op;
  logic [1:0][31:0]  opa, opb;
  logic [1:0]        grant;
  logic              done, busy;
  logic [31:0]       result_hi, result_lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  muldiv_unit_with_lock #(.NUM_PORTS(2), .ID_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .lock_req(lock_req), .lock_id(lock_id),
    .start(start), .op(op), .opa(opa), .opb(opb), .grant(grant),
    .done(done), .result_hi(result_hi), .result_lo(result_lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic straight from the instruction definitions
  task automatic calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] h, output logic [31:0] l);
    longint      la, lb, q, r;
    logic [63:0] p;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    case (o)
      2'd0: p = la * lb;
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = la / lb;
          r = la % lb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endtask

  // Transaction-level model of the lock protocol
  int          m_owner = -1;
  int          m_left  = 0;
  logic        m_done  = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] d;
        if (m_owner >= 0) d = lock_id[i] - lock_id[m_owner];
        else              d = '0;
        if (lock_req[i] && (m_owner < 0 || $signed(d) < 0)) m_owner = i;
      end
    end else if (!lock_req[m_owner]) begin
      m_owner = -1; m_left = 0; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
      end
    end else if (start[m_owner]) begin
      calc(op[m_owner], opa[m_owner], opb[m_owner], p_hi, p_lo);
      m_left = 32;
      m_done = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      logic [1:0] eg;
      eg = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
      chk("m_grant", {62'd0, grant}, {62'd0, eg});
      chk("m_busy", {63'd0, busy}, {63'd0, (m_owner >= 0)});
      chk("m_done", {63'd0, done}, {63'd0, m_done});
      chk("m_result", {result_hi, result_lo}, {m_hi, m_lo});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input int p, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start[p] = 1'b1; op[p] = o; opa[p] = a; opb[p] = b;
    t0 = cyc;
    tick();
    start = '0;
    chk("done_low_after_start", {63'd0, done}, 64'd0);
  endtask

  task automatic await_done(input string name);
    int guard = 0;
    while (!done && guard < 50) begin
      tick();
      guard++;
    end
    chk(name, cyc - t0, 33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lock_req = '0; lock_id = '0; start = '0; op = '0; opa = '0; opb = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_grant", {62'd0, grant}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);

    // Single signed multiply by port 0
    lock_req[0] = 1'b1; lock_id[0] = 16'd5;
    tick();
    chk("t2_grant", {62'd0, grant}, 64'd1);
    launch(0, 2'd0, 32'hFFFF_FFFD, 32'd7);
    await_done("t2_latency");
    chk("t2_result", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    lock_req[0] = 1'b0;
    tick();
    chk("t2_release_grant", {62'd0, grant}, 64'd0);
    chk("t2_release_done", {63'd0, done}, 64'd0);

    // Wrap-aware arbitration: 0xFFFE is older than 0x0001
    lock_req = 2'b11; lock_id[0] = 16'h0001; lock_id[1] = 16'hFFFE;
    tick();
    chk("t3_grant_wrap", {62'd0, grant}, 64'd2);
    lock_req[1] = 1'b0;
    tick();
    chk("t3_gap", {62'd0, grant}, 64'd0);
    tick();
    chk("t3_grant_next", {62'd0, grant}, 64'd1);

    // Signed divide, then divide-by-zero issued straight from DONE
    launch(0, 2'd2, 32'hFFFF_FFF9, 32'd2);
    await_done("t4_latency");
    chk("t4_div", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    launch(0, 2'd3, 32'd10, 32'd0);
    await_done("t4_divz_latency");
    chk("t4_divz", {result_hi, result_lo}, {32'd10, 32'hFFFF_FFFF});

    // Abort at BUSY cycle 10 while port 1 waits
    lock_req[1] = 1'b1; lock_id[1] = 16'd20;
    launch(0, 2'd1, 32'd123456789, 32'd987654321);
    repeat (9) tick();
    lock_req[0] = 1'b0;
    tick();
    chk("t5_abort_busy", {63'd0, busy}, 64'd0);
    chk("t5_abort_done", {63'd0, done}, 64'd0);
    tick();
    chk("t5_grant_waiter", {62'd0, grant}, 64'd2);
    chk("t5_results_held", {result_hi, result_lo}, {32'd10, 32'hFFFF_FFFF});

    // Non-owner starts ignored in LOCKED and BUSY; DIV overflow case
    lock_req[0] = 1'b1; lock_id[0] = 16'd30;
    start[0] = 1'b1; op[0] = 2'd1; opa[0] = 32'd3; opb[0] = 32'd3;
    tick();
    start = '0;
    chk("t6_nonowner_locked", {63'd0, done}, 64'd0);
    tick();
    launch(1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (3) tick();
    start[0] = 1'b1;
    tick();
    start = '0;
    await_done("t6_latency");
    chk("t6_div_ovf", {result_hi, result_lo}, {32'd0, 32'h8000_0000});
    launch(1, 2'd0, 32'h8000_0000, 32'h8000_0000);
    await_done("t6_mult_latency");
    chk("t6_mult_min", {result_hi, result_lo}, 64'h4000_0000_0000_0000);
    launch(1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    await_done("t6_multu_latency");
    chk("t6_multu_max", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
    lock_req[1] = 1'b0;
    tick(); tick();
    chk("t6_grant_port0", {62'd0, grant}, 64'd1);

    // Reset in the middle of BUSY
    launch(0, 2'd0, 32'd6, 32'd7);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("t1_rst_grant", {62'd0, grant}, 64'd0);
    chk("t1_rst_done", {63'd0, done}, 64'd0);
    chk("t1_rst_busy", {63'd0, busy}, 64'd0);
    chk("t1_rst_result", {result_hi, result_lo}, 64'd0);
    rst = 1'b0;
    lock_req = '0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
